// File: rtl/iic_arb_pkg.sv
// Shared types and constants for the I2C access arbiter.
package iic_arb_pkg;

    // Arbiter FSM states: one register transaction per IDLE->ISSUE->WAIT->RESP pass.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic       IIC_RD        = 1'b0;
    localparam logic       IIC_WR        = 1'b1;
    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iic_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping to 0.
module iic_rr_pick
    import iic_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vld,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      grant_idx,
    output logic               any
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest set request (from rr_ptr) wins last.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_vld[cand]) begin
                grant_idx = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_access_arbiter.sv
// Round-robin arbiter sharing one I2C byte master among NUM_REQ requesters,
// one register transaction at a time, with a bounded wait for master completion.
module iic_access_arbiter
    import iic_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 50_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [NUM_REQ-1:0]   req_wr,
    input  logic [7*NUM_REQ-1:0] req_dev,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic [NUM_REQ-1:0]   rsp_vld,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 m_start,
    output logic                 m_wr,
    output logic [6:0]           m_dev,
    output logic [7:0]           m_addr,
    output logic [7:0]           m_wdata,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic [7:0]           m_rdata,
    input  logic                 m_ack_err,
    output logic                 arb_busy
);

    localparam int            IW         = idx_width(NUM_REQ);
    localparam int            TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rr_ptr_q;
    logic [TW-1:0] timer_q;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          grant;
    logic          timed_out;

    logic [6:0] dev_arr   [NUM_REQ];
    logic [7:0] addr_arr  [NUM_REQ];
    logic [7:0] wdata_arr [NUM_REQ];

    // Unpack the flat per-requester command buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dev_arr[i]   = req_dev[7*i +: 7];
            addr_arr[i]  = req_addr[8*i +: 8];
            wdata_arr[i] = req_wdata[8*i +: 8];
        end
    end

    iic_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_vld   (req_vld),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // A grant only happens while idle and the master is free.
    assign grant     = (state_q == IDLE) && pick_any && !m_busy;
    assign timed_out = (timer_q == TIMER_LAST);
    assign arb_busy  = (state_q != IDLE);

    // State register.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and per-requester handshake pulses.
    always_comb begin
        state_d = state_q;
        req_rdy = '0;
        rsp_vld = '0;
        m_start = 1'b0;
        unique case (state_q)
            IDLE:  if (grant) state_d = ISSUE;
            ISSUE: begin
                req_rdy[owner_q] = 1'b1;
                m_start          = 1'b1;
                state_d          = WAIT;
            end
            WAIT:  if (m_done || timed_out) state_d = RESP;
            RESP: begin
                rsp_vld[owner_q] = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, owner/round-robin pointer, wait timer and response capture.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            owner_q  <= '0;
            rr_ptr_q <= '0;
            timer_q  <= '0;
            m_wr     <= 1'b0;
            m_dev    <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q <= pick_idx;
                        m_wr    <= req_wr[pick_idx];
                        m_dev   <= dev_arr[pick_idx];
                        m_addr  <= addr_arr[pick_idx];
                        m_wdata <= wdata_arr[pick_idx];
                    end
                end
                ISSUE: timer_q <= '0;
                WAIT: begin
                    // A completion on the final timer cycle still reports the master's result.
                    if (m_done) begin
                        rsp_data <= m_rdata;
                        rsp_err  <= m_ack_err;
                    end else if (timed_out) begin
                        rsp_data <= TIMEOUT_RDATA;
                        rsp_err  <= 1'b1;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: rr_ptr_q <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_access_arbiter.sv
// Self-checking bench for iic_access_arbiter: directed scenarios plus randomized
// traffic, predicted by a transaction-level round-robin model.
module tb_iic_access_arbiter;
    import iic_arb_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 100;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [N-1:0] req_vld = '0;
    logic [N-1:0] req_wr  = '0;
    logic [6:0]   r_dev   [N];
    logic [7:0]   r_addr  [N];
    logic [7:0]   r_wdata [N];
    logic [7*N-1:0] req_dev;
    logic [8*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0] req_rdy, rsp_vld;
    logic [7:0]   rsp_data;
    logic         rsp_err, m_start, m_wr, arb_busy;
    logic [6:0]   m_dev;
    logic [7:0]   m_addr, m_wdata;
    logic         m_busy    = 1'b0;
    logic         m_done    = 1'b0;
    logic [7:0]   m_rdata   = 8'h00;
    logic         m_ack_err = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_ptr = 0;

    assign req_dev   = {r_dev[1], r_dev[0]};
    assign req_addr  = {r_addr[1], r_addr[0]};
    assign req_wdata = {r_wdata[1], r_wdata[0]};

    iic_access_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_vld   (req_vld),
        .req_wr    (req_wr),
        .req_dev   (req_dev),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rdy   (req_rdy),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .m_start   (m_start),
        .m_wr      (m_wr),
        .m_dev     (m_dev),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .m_ack_err (m_ack_err),
        .arb_busy  (arb_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: first pending requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] v);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s = v >> ((exp_ptr + k) % N);
            if (s[0]) return (exp_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic set_req(input logic i, input logic wr, input logic [6:0] dev,
                           input logic [7:0] addr, input logic [7:0] wdata);
        req_wr[i]  = wr;
        r_dev[i]   = dev;
        r_addr[i]  = addr;
        r_wdata[i] = wdata;
        req_vld[i] = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy"},   32'(req_rdy),  32'h0);
        check({tag, "_rsp"},   32'(rsp_vld),  32'h0);
        check({tag, "_start"}, 32'(m_start),  32'h0);
        check({tag, "_busy"},  32'(arb_busy), 32'h0);
        check({tag, "_cmd"},   {7'h0, m_wr, m_dev, m_addr, m_wdata}, 32'h0);
        check({tag, "_rdata"}, {23'h0, rsp_err, rsp_data}, 32'h0);
    endtask

    // One full transaction from the current (negedge) point: grant, issue, master, response.
    task automatic serve(input string tag, input int exp_lat, input int dly,
                         input logic [7:0] rd, input logic nack, input bit tmo,
                         output logic [N-1:0] got);
        int         w;
        int         n;
        logic       wi;
        logic [7:0] exp_data;
        logic       exp_err;
        w  = model_pick(req_vld);
        wi = 1'(w);
        n  = 0;
        do begin @(negedge sys_clk); n++; end while (req_rdy == '0 && n < 300);
        got = req_rdy;
        check({tag, "_lat"},   32'(n),        32'(exp_lat));
        check({tag, "_rdy"},   32'(req_rdy),  32'(1) << w);
        check({tag, "_start"}, 32'(m_start),  32'h1);
        check({tag, "_busy"},  32'(arb_busy), 32'h1);
        check({tag, "_cmd"},   {7'h0, m_wr, m_dev, m_addr, m_wdata},
              {7'h0, req_wr[wi], r_dev[wi], r_addr[wi], r_wdata[wi]});
        req_vld[wi] = 1'b0;
        if (tmo) begin
            n = 0;
            do begin @(negedge sys_clk); n++; end while (rsp_vld == '0 && n < 300);
            check({tag, "_tmo_cyc"}, 32'(n), 32'(TMO + 1));
            exp_data = TIMEOUT_RDATA;
            exp_err  = 1'b1;
        end else begin
            repeat (dly) @(negedge sys_clk);
            check({tag, "_early"}, 32'(rsp_vld), 32'h0);
            m_done    = 1'b1;
            m_rdata   = rd;
            m_ack_err = nack;
            @(negedge sys_clk);
            m_done    = 1'b0;
            m_rdata   = 8'($urandom);
            m_ack_err = 1'b0;
            exp_data  = rd;
            exp_err   = nack;
        end
        check({tag, "_rsp"},  32'(rsp_vld), 32'(1) << w);
        check({tag, "_data"}, {23'h0, rsp_err, rsp_data}, {23'h0, exp_err, exp_data});
        exp_ptr = (w + 1) % N;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] got;
        for (int i = 0; i < N; i++) begin
            r_dev[i] = '0; r_addr[i] = '0; r_wdata[i] = '0;
        end

        // Reset state.
        repeat (3) @(negedge sys_clk);
        check_quiet("reset");
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Single read by requester 0.
        set_req(1'b0, IIC_RD, 7'h54, 8'h00, 8'h00);
        serve("single", 1, 3, 8'h5A, 1'b0, 1'b0, got);

        // NACKed write by requester 1.
        @(negedge sys_clk);
        set_req(1'b1, IIC_WR, 7'h48, 8'h01, 8'h80);
        serve("nack", 1, 2, 8'h00, 1'b1, 1'b0, got);

        // Contention: both requesters held, reasserting in their response cycle.
        @(negedge sys_clk);
        set_req(1'b0, IIC_RD, 7'h10, 8'h20, 8'h00);
        set_req(1'b1, IIC_WR, 7'h11, 8'h21, 8'h33);
        for (int t = 0; t < 4; t++) begin
            serve("cont", (t == 0) ? 1 : 2, 1 + t, 8'(8'hC0 + t), 1'b0, 1'b0, got);
            check("cont_order", 32'(got), 32'(1) << (t % 2));
            req_vld = req_vld | got;
        end

        // Request withdrawn before its grant edge is not served.
        req_vld = '0;
        repeat (3) begin
            @(negedge sys_clk);
            check("withdrawn_rdy", 32'(req_rdy), 32'h0);
        end

        // Master busy blocks the grant until it falls.
        m_busy = 1'b1;
        set_req(1'b0, IIC_WR, 7'h22, 8'h44, 8'h66);
        repeat (20) begin
            @(negedge sys_clk);
            check("mbusy_hold", {30'h0, arb_busy, req_rdy[0]}, 32'h0);
        end
        m_busy = 1'b0;
        serve("mbusy_rel", 1, 4, 8'h77, 1'b0, 1'b0, got);

        // Timeout: master never completes.
        @(negedge sys_clk);
        set_req(1'b1, IIC_RD, 7'h31, 8'h05, 8'h00);
        serve("timeout", 1, 0, 8'h00, 1'b0, 1'b1, got);

        // Stray m_done while idle is ignored.
        @(negedge sys_clk);
        m_done = 1'b1;
        @(negedge sys_clk);
        m_done = 1'b0;
        check("stray_done", {30'h0, arb_busy, |rsp_vld}, 32'h0);
        @(negedge sys_clk);
        check("stray_done2", 32'(rsp_vld), 32'h0);

        // Reset during WAIT abandons the transaction silently.
        set_req(1'b0, IIC_RD, 7'h3C, 8'h0F, 8'h00);
        @(negedge sys_clk);
        check("rstmid_rdy", 32'(req_rdy), 32'h1);
        req_vld = '0;
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_quiet("rstmid");
        sys_rst = 1'b0;
        exp_ptr = 0;
        repeat (3) begin
            @(negedge sys_clk);
            check("rstmid_norsp", 32'(rsp_vld), 32'h0);
        end
        set_req(1'b0, IIC_RD, 7'h3C, 8'h0F, 8'h00);
        serve("post_rst", 1, 2, 8'hA5, 1'b0, 1'b0, got);

        // Randomized traffic against the round-robin model.
        for (int it = 0; it < 40; it++) begin
            @(negedge sys_clk);
            for (int i = 0; i < N; i++) begin
                if (req_vld[1'(i)] == 1'b0 && $urandom_range(0, 1) == 1)
                    set_req(1'(i), 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            end
            if (req_vld == '0)
                set_req(1'b0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            serve("rand", 1, $urandom_range(1, 12), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
